register_32b: RTL and testbench
===============================

# register_32b

General-purpose 32-bit storage register with write enable and asynchronous clear. It is the basic state element of the datapath register file and the special-purpose registers (PC, IR, MAR/MDR style holders). It captures `D` on the rising clock edge when `Write` is high and holds its value otherwise.

## Interface
Parameters:
- `WIDTH`, default 32: data width. Must be a multiple of 8 when `REGISTER_32B_BYTE_WRITE_EN` is defined.
- `RESET_VALUE`, default 0: value loaded into `Q` by `Clear`. Width is `WIDTH`.

Ports:
- `Clock`: input, 1 bit. Single clock; the register samples on the rising edge.
- `Clear`: input, 1 bit. Reset is asynchronous and active-high; `Clock` is the one clock.
- `Write`: input, 1 bit. Synchronous load enable, active-high.
- `D`: input, `WIDTH` bits. Data to load.
- `Q`: output, `WIDTH` bits. Registered contents, driven directly from the flops.
- `ByteEn`: input, `WIDTH/8` bits. Exists only when `REGISTER_32B_BYTE_WRITE_EN` is defined. Bit i enables byte lane i, which is `D[8i+7:8i]`.

## Operation
- `Clear` high: `Q` = `RESET_VALUE` immediately, with no clock needed. `Q` stays there while `Clear` is held high, regardless of `Clock`, `Write` and `D`.
- `Clear` low, rising edge of `Clock`, `Write`=1: `Q` <= `D`, all bits, unless byte writes are configured.
- `Clear` low, rising edge, `Write`=0: `Q` holds.
- Priority: `Clear` > `Write` > hold.
- Rewriting the same value is legal. `Q` is unchanged and has no glitch.
- No arithmetic and no width conversion. `D` and `Q` are the same width, bit-for-bit.
- Power-up without a `Clear` pulse: `Q` is undefined (X in simulation). System reset must pulse `Clear` before `Q` is used.

## Timing
- Write latency is 1 cycle. `D` and `Write` are sampled at rising edge N, and `Q` shows the new value after edge N with clock-to-q delay only.
- Clear latency is 0 cycles. `Q` changes asynchronously on the rising edge of `Clear`, within flop reset-to-q delay.
- Clear release: deassertion is synchronized by the system reset controller. The first load can happen on the first rising edge after `Clear` falls, provided `Write`=1.
- `Clear` asserted in the same cycle as `Write`=1: the clear wins, the write is discarded, and `Q` = `RESET_VALUE`.
- Clear asserted mid-cycle after a write: `Q` drops to `RESET_VALUE` immediately. The written value is lost.
- `Q` has no combinational path from `D` or `Write`.

## Configuration
- Macro `REGISTER_32B_BYTE_WRITE_EN`.
- Defined:
  - The `ByteEn` port exists.
  - On a write edge (`Write`=1), byte lane i loads `D` lane i only when `ByteEn[i]`=1. Other lanes hold.
  - `Write`=0 blocks every lane whatever `ByteEn` is.
  - `Clear` resets all lanes.
- Not defined:
  - No `ByteEn` port.
  - `Write`=1 loads the full word.

## Test plan
- Reset: `Clear`=1 with no clock edge. Required: `Q`=0x0000_0000 within the same timestep; it holds through 2 clock edges with `Write`=1 and `D`=0xFFFF_FFFF.
- Hold: after clear, `Clear`=0, `Write`=0, `D`=0x0000_0000, one edge. Required: `Q` stays 0x0000_0000. Then `D`=0x1234_5678 with `Write`=0. Required: `Q` is still 0.
- Load and rewrite: `D`=0x0000_0003, `Write`=1, rising edge. Required: `Q`=0x0000_0003 after that edge, not before. A second edge with the same `D` gives `Q`=0x0000_0003 with no toggle.
- Async clear mid-cycle: `Q`=0x0000_0003, `Clock` low, raise `Clear`. Required: `Q`=0x0000_0000 before the next rising edge; it stays 0 on the following edge with `Write`=1.
- Clear/write collision: `Clear`=1 and `Write`=1 with `D`=0xDEAD_BEEF across an edge. Required: `Q`=0. Release `Clear`, then at the next edge: `Q`=0xDEAD_BEEF.
- Byte write (macro defined): `Q`=0, `ByteEn`=4'b0101, `D`=0xAABB_CCDD, `Write`=1. Required: `Q`=0x00BB_00DD. With the macro undefined, the same stimulus without `ByteEn` gives `Q`=0xAABB_CCDD.

Source files
------------

// File: rtl/register_32b.sv
// ---------------------------------------------------------------------------
// register_32b
//
// General-purpose storage register with a synchronous write enable and an
// asynchronous active-high clear. Used as the basic state element of the
// datapath register file and of special-purpose holders (PC, IR, MAR/MDR).
//
// Optional feature macro: REGISTER_32B_BYTE_WRITE_EN
//   Undefined (default): Write=1 loads the whole word.
//   Defined: adds the ByteEn port; on a write edge only enabled byte lanes load.
//
// Parameters:
//   WIDTH        data width (multiple of 8 when byte writes are enabled)
//   RESET_VALUE  value forced onto Q while Clear is high
//
// Ports:
//   Clock   in   rising-edge clock
//   Clear   in   asynchronous active-high clear, highest priority
//   Write   in   synchronous load enable, active-high
//   D       in   WIDTH-bit data to load
//   ByteEn  in   WIDTH/8 lane enables (only with REGISTER_32B_BYTE_WRITE_EN)
//   Q       out  WIDTH-bit register contents, straight from the flops
// ---------------------------------------------------------------------------
module register_32b #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic                     Clock,
    input  logic                     Clear,
    input  logic                     Write,
    input  logic [WIDTH-1:0]         D,
`ifdef REGISTER_32B_BYTE_WRITE_EN
    input  logic [WIDTH/8-1:0]       ByteEn,
`endif
    output logic [WIDTH-1:0]         Q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

`ifdef REGISTER_32B_BYTE_WRITE_EN
    if ((WIDTH % 8) != 0) begin : g_width_check
        $error("register_32b: WIDTH must be a multiple of 8 with byte writes");
    end

    // Merge enabled lanes of D over the current contents; disabled lanes hold.
    always_comb begin
        w_next = r_q;
        for (int i = 0; i < int'(WIDTH / 8); i++) begin
            if (ByteEn[i]) begin
                w_next[8*i +: 8] = D[8*i +: 8];
            end
        end
    end
`else
    assign w_next = D;
`endif

    // Clear > Write > hold. Rewriting the same value leaves Q untouched.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_q <= RESET_VALUE;
        end else if (Write) begin
            r_q <= w_next;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_register_32b.sv
module tb_register_32b;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Write = 1'b0;
    logic [31:0] D     = '0;
    logic [3:0]  ByteEn = 4'hF;
    logic [31:0] Q;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_q;

    always #5 Clock = ~Clock;

    register_32b #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) u_dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .Write  (Write),
        .D      (D),
`ifdef REGISTER_32B_BYTE_WRITE_EN
        .ByteEn (ByteEn),
`endif
        .Q      (Q)
    );

    typedef struct {
        logic        clr;
        logic        wr;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: Q=%h expected %h", name, act, exp);
        end
    endtask

    // Reference: a write replaces exactly the bytes whose enable is set.
    function automatic logic [31:0] model_write(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
`ifdef REGISTER_32B_BYTE_WRITE_EN
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
`else
        mask = 32'hFFFF_FFFF;
`endif
        return (old & ~mask) | (d & mask);
    endfunction

    initial begin
        // Table: each entry driven at a falling edge, checked just after the next rising edge.
        vecs[0] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5};
`ifdef REGISTER_32B_BYTE_WRITE_EN
        vecs[3] = '{1'b0, 1'b1, 32'h1122_3344, 4'h3, 32'hA5A5_3344};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'hA5A5_3344};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'hA5A5_3344};
        vecs[6] = '{1'b0, 1'b1, 32'hCAFE_F00D, 4'h8, 32'hCAA5_3344};
`else
        vecs[3] = '{1'b0, 1'b1, 32'h1122_3344, 4'h3, 32'h1122_3344};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 1'b1, 32'hCAFE_F00D, 4'h8, 32'hCAFE_F00D};
`endif
        vecs[7] = '{1'b1, 1'b0, 32'h1234_5678, 4'hF, 32'h0000_0000};

        // Reset: asynchronous, no clock edge before the check.
        #1;
        Clear = 1'b1; Write = 1'b1; D = 32'hFFFF_FFFF;
        #1 check("reset_async", Q, 32'h0);
        repeat (2) @(posedge Clock);
        #1 check("reset_hold_edges", Q, 32'h0);

        // Hold.
        @(negedge Clock);
        Clear = 1'b0; Write = 1'b0; D = 32'h0;
        @(posedge Clock); #1 check("hold_zero", Q, 32'h0);
        @(negedge Clock);
        D = 32'h1234_5678;
        @(posedge Clock); #1 check("hold_no_write", Q, 32'h0);

        // Load and rewrite.
        @(negedge Clock);
        D = 32'h0000_0003; Write = 1'b1;
        #1 check("load_not_before_edge", Q, 32'h0);
        @(posedge Clock); #1 check("load", Q, 32'h3);
        @(posedge Clock); #1 check("rewrite_same", Q, 32'h3);

        // Async clear mid-cycle with the clock low.
        @(negedge Clock);
        #1 Clear = 1'b1;
        #1 check("clear_mid_cycle", Q, 32'h0);
        @(posedge Clock); #1 check("clear_beats_write", Q, 32'h0);

        // Clear/write collision, then first write after release.
        @(negedge Clock);
        D = 32'hDEAD_BEEF; Write = 1'b1;
        @(posedge Clock); #1 check("collision", Q, 32'h0);
        @(negedge Clock);
        Clear = 1'b0;
        @(posedge Clock); #1 check("first_after_release", Q, 32'hDEAD_BEEF);

        // Byte write from a cleared register.
        @(negedge Clock);
        Clear = 1'b1;
        #1 Clear = 1'b0;
        D = 32'hAABB_CCDD; ByteEn = 4'b0101; Write = 1'b1;
        @(posedge Clock);
`ifdef REGISTER_32B_BYTE_WRITE_EN
        #1 check("byte_write", Q, 32'h00BB_00DD);
        @(negedge Clock);
        Write = 1'b0; ByteEn = 4'hF; D = 32'h0;
        @(posedge Clock); #1 check("byte_write_blocked", Q, 32'h00BB_00DD);
`else
        #1 check("full_write", Q, 32'hAABB_CCDD);
`endif

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            Clear = vecs[i].clr; Write = vecs[i].wr; D = vecs[i].d; ByteEn = vecs[i].be;
            @(posedge Clock);
            #1 check($sformatf("vec%0d", i), Q, vecs[i].exp);
        end
        m_q = 32'h0;

        // Randomized run against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic clr;
            @(negedge Clock);
            clr    = ($urandom_range(0, 15) == 0);
            Clear  = clr;
            Write  = 1'($urandom_range(0, 1));
            D      = $urandom;
            ByteEn = 4'($urandom_range(0, 15));
            if (clr) begin
                m_q = 32'h0;
                #1 check($sformatf("rand_async_clear%0d", n), Q, m_q);
            end else if (Write) begin
                m_q = model_write(m_q, D, ByteEn);
            end
            @(posedge Clock);
            #1 check($sformatf("rand%0d", n), Q, m_q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
